// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM driver: one shared frame timer, per-channel angle
// target with a per-frame slew limit, and width/enable changes only at frame edges.
module servo_pwm_multi #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int PWM_FREQ    = 50,
    parameter int NUM_CH      = 4,
    parameter int MIN_US      = 500,
    parameter int US_PER_DEG  = 11,
    parameter int STEP_DEG    = 0,
    parameter int RESET_ANGLE = 0,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [7:0]        cmd_angle,
    input  logic              cmd_enable,
    output logic              cmd_err,
    output logic [NUM_CH-1:0] servo_out,
    output logic [NUM_CH-1:0] at_target,
    output logic              frame_start
);

    localparam int TICKS     = CLK_FREQ / 1_000_000;
    localparam int PERIOD_US = 1_000_000 / PWM_FREQ;
    localparam int PRE_W     = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int US_W      = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam int WID_W     = $clog2(MIN_US + 180 * US_PER_DEG + 1);
    localparam int CMP_W     = (US_W > WID_W) ? US_W : WID_W;

    localparam logic [7:0]       MAX_ANGLE = 8'd180;
    localparam logic [7:0]       STEP_8    = 8'(STEP_DEG);
    localparam logic [7:0]       RESET_8   = 8'(RESET_ANGLE);
    localparam logic [WID_W-1:0] RESET_WID = WID_W'(MIN_US + RESET_ANGLE * US_PER_DEG);
    localparam logic [CH_W:0]    NUM_CH_V  = (CH_W + 1)'(NUM_CH);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICKS - 1);
    localparam logic [US_W-1:0]  US_LAST   = US_W'(PERIOD_US - 1);

    if ((CLK_FREQ < 1_000_000) || ((CLK_FREQ % 1_000_000) != 0)) begin : g_bad_clk
        $error("servo_pwm_multi: CLK_FREQ must be a non-zero multiple of 1 MHz");
    end
    if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_num_ch
        $error("servo_pwm_multi: NUM_CH must be in 1..16");
    end

    function automatic logic [WID_W-1:0] angle_to_width(input logic [7:0] angle);
        return WID_W'(MIN_US) + WID_W'(angle) * WID_W'(US_PER_DEG);
    endfunction

    function automatic logic [7:0] slew_step(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] res;
        if (STEP_DEG == 0) begin
            res = tgt;
        end else if (tgt > cur) begin
            res = ((tgt - cur) > STEP_8) ? (cur + STEP_8) : tgt;
        end else if (cur > tgt) begin
            res = ((cur - tgt) > STEP_8) ? (cur - STEP_8) : tgt;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    logic [PRE_W-1:0]                pre_q, pre_d;
    logic [US_W-1:0]                 us_q, us_d;
    logic [NUM_CH-1:0][7:0]          tgt_q, tgt_d;
    logic [NUM_CH-1:0][7:0]          cur_q, cur_d;
    logic [NUM_CH-1:0][WID_W-1:0]    wid_q, wid_d;
    logic [NUM_CH-1:0]               en_req_q, en_req_d;
    logic [NUM_CH-1:0]               en_lat_q, en_lat_d;
    logic [NUM_CH-1:0]               servo_q, servo_d;
    logic [NUM_CH-1:0]               at_q, at_d;
    logic                            ready_q, err_q, err_d, fs_q;
    logic                            pre_wrap_s, frame_tick_s, accept_s, ch_ok_s;
    logic [7:0]                      angle_clamp_s;

    // Timebase: microsecond prescaler and frame position counter.
    always_comb begin
        pre_wrap_s   = (pre_q == PRE_LAST);
        frame_tick_s = pre_wrap_s && (us_q == US_LAST);
        pre_d        = pre_q;
        us_d         = us_q;
        if (pre_wrap_s) begin
            pre_d = {PRE_W{1'b0}};
            us_d  = (us_q == US_LAST) ? {US_W{1'b0}} : (us_q + {{(US_W-1){1'b0}}, 1'b1});
        end else begin
            pre_d = pre_q + {{(PRE_W-1){1'b0}}, 1'b1};
            us_d  = us_q;
        end
    end

    // Per-channel command capture, frame-boundary slew/latch and output compare.
    always_comb begin
        accept_s      = cmd_valid && ready_q;
        ch_ok_s       = ({1'b0, cmd_ch} < NUM_CH_V);
        angle_clamp_s = (cmd_angle > MAX_ANGLE) ? MAX_ANGLE : cmd_angle;
        err_d         = accept_s && !ch_ok_s;
        tgt_d         = tgt_q;
        cur_d         = cur_q;
        wid_d         = wid_q;
        en_req_d      = en_req_q;
        en_lat_d      = en_lat_q;
        servo_d       = {NUM_CH{1'b0}};
        at_d          = at_q;
        for (int i = 0; i < NUM_CH; i++) begin
            // The slew always sees the target held before this cycle's command.
            if (frame_tick_s) begin
                cur_d[i]    = slew_step(cur_q[i], tgt_q[i]);
                wid_d[i]    = angle_to_width(cur_d[i]);
                en_lat_d[i] = en_req_q[i];
            end else begin
                cur_d[i]    = cur_q[i];
                wid_d[i]    = wid_q[i];
                en_lat_d[i] = en_lat_q[i];
            end
            if (accept_s && ch_ok_s && (cmd_ch == CH_W'(i))) begin
                tgt_d[i]    = angle_clamp_s;
                en_req_d[i] = cmd_enable;
            end else begin
                tgt_d[i]    = tgt_q[i];
                en_req_d[i] = en_req_q[i];
            end
            at_d[i]    = (cur_d[i] == tgt_d[i]);
            servo_d[i] = en_lat_q[i] && (CMP_W'(us_q) < CMP_W'(wid_q[i]));
        end
    end

    // State registers; asynchronous reset forces every output to its idle value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= {PRE_W{1'b0}};
            us_q     <= {US_W{1'b0}};
            tgt_q    <= {NUM_CH{RESET_8}};
            cur_q    <= {NUM_CH{RESET_8}};
            wid_q    <= {NUM_CH{RESET_WID}};
            en_req_q <= {NUM_CH{1'b1}};
            en_lat_q <= {NUM_CH{1'b1}};
            servo_q  <= {NUM_CH{1'b0}};
            at_q     <= {NUM_CH{1'b1}};
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            us_q     <= us_d;
            tgt_q    <= tgt_d;
            cur_q    <= cur_d;
            wid_q    <= wid_d;
            en_req_q <= en_req_d;
            en_lat_q <= en_lat_d;
            servo_q  <= servo_d;
            at_q     <= at_d;
            ready_q  <= 1'b1;
            err_q    <= err_d;
            fs_q     <= frame_tick_s;
        end
    end

    assign cmd_ready   = ready_q;
    assign cmd_err     = err_q;
    assign servo_out   = servo_q;
    assign at_target   = at_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Scoreboard bench for servo_pwm_multi: two instances (jump and 30-degree slew)
// share one command stream; per-frame pulse lengths are checked against a model.
module tb_servo_pwm_multi;

    localparam int TICKS  = 2;
    localparam int FRAME  = 5000;
    localparam int MIN_US = 500;
    localparam int UPD    = 11;

    logic       clk, rst_n, cmd_valid, cmd_enable;
    logic [1:0] cmd_ch;
    logic [7:0] cmd_angle;
    logic       ready_a, ready_b, err_a, err_b, fs_a, fs_b;
    logic [3:0] servo_a, at_a;
    logic [2:0] servo_b, at_b;

    servo_pwm_multi #(.CLK_FREQ(2_000_000), .PWM_FREQ(400), .NUM_CH(4), .MIN_US(MIN_US),
                      .US_PER_DEG(UPD), .STEP_DEG(0), .RESET_ANGLE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_a),
        .cmd_ch(cmd_ch), .cmd_angle(cmd_angle), .cmd_enable(cmd_enable), .cmd_err(err_a),
        .servo_out(servo_a), .at_target(at_a), .frame_start(fs_a));

    servo_pwm_multi #(.CLK_FREQ(2_000_000), .PWM_FREQ(400), .NUM_CH(3), .MIN_US(MIN_US),
                      .US_PER_DEG(UPD), .STEP_DEG(30), .RESET_ANGLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(ready_b),
        .cmd_ch(cmd_ch), .cmd_angle(cmd_angle), .cmd_enable(cmd_enable), .cmd_err(err_b),
        .servo_out(servo_b), .at_target(at_b), .frame_start(fs_b));

    int cyc = 0;
    int m_tgt[2][4];
    int m_cur[2][4];
    bit m_en[2][4];
    int exp_q[8][$];
    int err_q[2][$];
    int cnt[2][4];
    int n_pass = 0;
    int n_total = 0;

    function automatic int nch_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int step_of(input int d);
        return (d == 0) ? 0 : 30;
    endfunction

    function automatic int exp_width(input int ang, input bit en);
        return en ? (MIN_US + ang * UPD) * TICKS : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: frame ticks from cycle arithmetic, angles as plain integers.
    task automatic model_reset();
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            err_q[d].delete();
            for (int ch = 0; ch < 4; ch++) begin
                m_tgt[d][ch] = 0;
                m_cur[d][ch] = 0;
                m_en[d][ch]  = 1'b1;
                exp_q[d*4+ch].delete();
                if (ch < nch_of(d)) exp_q[d*4+ch].push_back(exp_width(0, 1'b1));
            end
        end
    endtask

    task automatic model_step();
        int diff, st;
        if (cyc % FRAME == FRAME - 1) begin
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < nch_of(d); ch++) begin
                    diff = m_tgt[d][ch] - m_cur[d][ch];
                    st   = step_of(d);
                    if (st == 0) m_cur[d][ch] = m_tgt[d][ch];
                    else if (diff > 0) m_cur[d][ch] += (diff < st) ? diff : st;
                    else m_cur[d][ch] -= (-diff < st) ? -diff : st;
                    exp_q[d*4+ch].push_back(exp_width(m_cur[d][ch], m_en[d][ch]));
                end
            end
        end
        if (cmd_valid && cyc >= 1) begin
            for (int d = 0; d < 2; d++) begin
                if (int'(cmd_ch) < nch_of(d)) begin
                    m_tgt[int'(d)][cmd_ch] = (cmd_angle > 8'd180) ? 180 : int'(cmd_angle);
                    m_en[int'(d)][cmd_ch]  = cmd_enable;
                end else begin
                    err_q[d].push_back(cyc + 1);
                end
            end
        end
        cyc++;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Monitor: measures each frame's pulse length and pops the expected value.
    initial begin
        logic       fs_v, err_v, exp_fs, exp_err;
        logic [3:0] sv, at_v, at_exp;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int d = 0; d < 2; d++)
                    for (int ch = 0; ch < 4; ch++) cnt[d][ch] = 0;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    fs_v   = (d == 0) ? fs_a : fs_b;
                    err_v  = (d == 0) ? err_a : err_b;
                    sv     = (d == 0) ? servo_a : {1'b0, servo_b};
                    at_v   = (d == 0) ? at_a : {1'b0, at_b};
                    at_exp = 4'b0000;
                    for (int ch = 0; ch < nch_of(d); ch++)
                        at_exp[ch] = (m_cur[d][ch] == m_tgt[d][ch]);
                    exp_fs = (cyc > 0) && (cyc % FRAME == 0);
                    if (fs_v || exp_fs) check($sformatf("frame_start dut%0d", d), fs_v, exp_fs);
                    if (fs_v) begin
                        for (int ch = 0; ch < nch_of(d); ch++) begin
                            if (exp_q[d*4+ch].size() > 0)
                                check($sformatf("pulse cycles dut%0d ch%0d", d, ch),
                                      cnt[d][ch], exp_q[d*4+ch].pop_front());
                            else
                                check($sformatf("pending frame dut%0d ch%0d", d, ch),
                                      exp_q[d*4+ch].size(), 1);
                            cnt[d][ch] = 0;
                        end
                    end
                    if (fs_v || (cyc % 97 == 0))
                        check($sformatf("at_target dut%0d", d), at_v, at_exp);
                    exp_err = (err_q[d].size() > 0) && (err_q[d][0] == cyc);
                    if (err_v || ((err_q[d].size() > 0) && (err_q[d][0] <= cyc))) begin
                        check($sformatf("cmd_err dut%0d", d), err_v, exp_err);
                        if ((err_q[d].size() > 0) && (err_q[d][0] <= cyc)) void'(err_q[d].pop_front());
                    end
                    for (int ch = 0; ch < nch_of(d); ch++) cnt[d][ch] += int'(sv[ch]);
                end
            end
        end
    end

    initial begin
        repeat (90_000) @(posedge clk);
        $display("FAIL watchdog: got cycle budget expired, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic goto_cycle(input int target);
        int guard = 0;
        while (cyc != target && guard < 3 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) check("goto cycle", cyc, target);
        #1;
    endtask

    task automatic issue(input int ch, input int ang, input bit en);
        cmd_valid  = 1'b1;
        cmd_ch     = 2'(ch);
        cmd_angle  = 8'(ang);
        cmd_enable = en;
        @(negedge clk);
        #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("reset servo_out a", servo_a, 0);
        check("reset servo_out b", servo_b, 0);
        check("reset cmd_ready", {ready_a, ready_b}, 0);
        check("reset cmd_err", {err_a, err_b}, 0);
        check("reset frame_start", {fs_a, fs_b}, 0);
        check("reset at_target a", at_a, 4'hF);
        check("reset at_target b", at_b, 3'h7);
    endtask

    initial begin
        int gap;
        int guard;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_ch     = 2'd0;
        cmd_angle  = 8'd0;
        cmd_enable = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        #1;
        check("cmd_ready at release", {ready_a, ready_b}, 0);
        @(posedge clk);
        #1;
        check("cmd_ready after release", {ready_a, ready_b}, 2'b11);

        goto_cycle(FRAME + 100);
        issue(1, 90, 1'b1);
        goto_cycle(FRAME + 130);
        issue(0, 100, 1'b1);
        goto_cycle(FRAME + 160);
        issue(3, 200, 1'b1);

        goto_cycle(2 * FRAME + 300);
        issue(2, 0, 1'b0);
        goto_cycle(2 * FRAME + 400);
        check("disabled ch2 pulse still running", servo_a[2], 1);
        goto_cycle(3 * FRAME + 300);
        check("disabled ch2 held low", servo_a[2], 0);
        goto_cycle(4 * FRAME - 1);
        issue(2, 45, 1'b1);
        goto_cycle(4 * FRAME + 50);
        issue(0, 10, 1'b1);

        goto_cycle(5 * FRAME + 200);
        guard = 0;
        while (cyc < 10 * FRAME + 3000 && guard < 1000) begin
            gap = $urandom_range(40, 700);
            repeat (gap) @(negedge clk);
            #1;
            issue($urandom_range(0, 3), $urandom_range(0, 255), ($urandom_range(0, 3) != 0));
            guard++;
        end

        goto_cycle(11 * FRAME + 100);
        issue(1, 90, 1'b1);
        goto_cycle(12 * FRAME + 400);
        check("ch1 pulse active before reset", servo_a[1], 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("cmd_ready at re-release", {ready_a, ready_b}, 0);
        @(posedge clk);
        #1;
        check("cmd_ready after re-release", {ready_a, ready_b}, 2'b11);

        goto_cycle(2 * FRAME + 10);
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < nch_of(d); ch++)
                check($sformatf("frames left dut%0d ch%0d", d, ch), exp_q[d*4+ch].size(), 1);
            check($sformatf("cmd_err left dut%0d", d), err_q[d].size(), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
